example: RTL and testbench

EXAMPLE -- requirements
Module: example

---
 rtl/example.sv | 227 ++++++++++++++++++++++
 tb/tb_example.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/example.sv
// ---------------------------------------------------------------------------
// example -- Smith-Waterman local alignment engine (linear gap penalty).
//
// A systolic row of QLEN processing elements scores a fixed query against a
// fixed database. Both sequences are constant tables of 2-bit nucleotide
// codes (A=0, C=1, G=2, T=3). The tables are packed vectors in which symbol k
// occupies bits [2k+1:2k]. The alignment runs exactly once after each reset
// release, and the best score is then held.
//
// Ports
//   clk   : rising-edge clock for all state
//   rst   : asynchronous active-low reset; 0 clears every register
//   score : best local-alignment score (unsigned, 10 bits). It reads 0 until
//           the run completes and then holds the final value.
//
// Control sequence: IDLE -> RUN (DLEN cycles) -> DRAIN (QLEN cycles)
//                   -> REDUCE (1 cycle) -> DONE (held).
// The current FSM state is available on the internal signal `state` for
// probing.
// ---------------------------------------------------------------------------
module example #(
  parameter int QLEN     = 16,
  parameter int DLEN     = 32,
  parameter int MATCH    = 2,
  parameter int MISMATCH = 1,
  parameter int GAP      = 1,
  // Query: ACGT repeated. The default literal assumes QLEN = 16.
  parameter logic [2*QLEN-1:0] QSEQ = 32'hE4E4_E4E4,
  // Database: TTTTTTTT, then the query, then GGGGGGGG. The default literal
  // assumes DLEN = 32.
  parameter logic [2*DLEN-1:0] DSEQ = 64'hAAAA_E4E4_E4E4_FFFF
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] score
);

  localparam int CMAX = (DLEN > QLEN) ? DLEN : QLEN;
  localparam int CW   = $clog2(CMAX + 1);

  // Cell arithmetic is 12-bit signed. This holds 1023 + MATCH without
  // wrapping, and it also holds the negative mismatch and gap terms.
  localparam logic signed [11:0] S_MATCH = 12'(MATCH);
  localparam logic signed [11:0] S_MIS   = 12'(-MISMATCH);
  localparam logic signed [11:0] S_GAP   = 12'(GAP);
  localparam logic signed [11:0] H_SAT   = 12'sd1023;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    REDUCE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          feed_vld;
  logic [1:0]    feed_sym;
  logic          load_score;

  // -------------------------------------------------------------------------
  // Control FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM: next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    feed_vld   = 1'b0;
    feed_sym   = 2'd0;
    load_score = 1'b0;
    case (state)
      IDLE: begin
        state_nx = RUN;
        cnt_nx   = '0;
      end
      RUN: begin
        // cnt is the database index that PE 0 consumes in this cycle.
        feed_vld = 1'b1;
        feed_sym = DSEQ[2*int'(cnt) +: 2];
        if (cnt == CW'(DLEN - 1)) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DRAIN: begin
        // Bubbles enter PE 0 while the last real symbol moves to the end of
        // the array.
        if (cnt == CW'(QLEN - 1)) begin
          state_nx = REDUCE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      REDUCE: begin
        load_score = 1'b1;
        state_nx   = DONE;
      end
      DONE: begin
        state_nx = DONE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Systolic array
  //
  // Symbol stream: PE i processes its input in any cycle where its input
  // valid is high, and the stream has no backpressure. A symbol enters PE 0
  // from the feed and reaches PE i exactly i cycles later. In that cycle, the
  // H value it carries is H(i-1, j), the value PE i-1 computed for the same
  // symbol. When the valid is low, the cycle is a bubble and no register
  // except the valid pipeline changes.
  //
  // Per-PE registers:
  //   h_r  : H(i, j-1), the last H value this PE produced
  //          (reset to 0, which gives the H(i,-1) boundary)
  //   dg_r : H(i-1, j-1), the upstream H value received with the previous
  //          symbol (reset to 0, which gives the diagonal boundary)
  //   mx_r : running maximum of h_r
  // -------------------------------------------------------------------------
  logic [1:0] sym_a  [QLEN];
  logic       vld_a  [QLEN];
  logic [9:0] h_a    [QLEN];
  logic [9:0] pmax_a [QLEN];

  for (genvar i = 0; i < QLEN; i++) begin : g_pe
    logic [1:0]        in_sym;
    logic              in_vld;
    logic [9:0]        in_h;
    logic [1:0]        sym_r;
    logic              vld_r;
    logic [9:0]        h_r;
    logic [9:0]        dg_r;
    logic [9:0]        mx_r;
    logic signed [11:0] diag_t, up_t, left_t, best;
    logic [9:0]        h_new;

    if (i == 0) begin : g_head
      // PE 0 sees the H(-1, *) boundary row, which is all zeros.
      assign in_sym = feed_sym;
      assign in_vld = feed_vld;
      assign in_h   = 10'd0;
    end else begin : g_link
      assign in_sym = sym_a[i-1];
      assign in_vld = vld_a[i-1];
      assign in_h   = h_a[i-1];
    end

    always_comb begin
      diag_t = $signed({2'b00, dg_r}) +
               ((in_sym == QSEQ[2*i +: 2]) ? S_MATCH : S_MIS);
      up_t   = $signed({2'b00, in_h}) - S_GAP;
      left_t = $signed({2'b00, h_r}) - S_GAP;
      best   = 12'sd0;
      if (diag_t > best) best = diag_t;
      if (up_t   > best) best = up_t;
      if (left_t > best) best = left_t;
      if (best > H_SAT) h_new = 10'd1023;
      else              h_new = best[9:0];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sym_r <= 2'd0;
        vld_r <= 1'b0;
        h_r   <= 10'd0;
        dg_r  <= 10'd0;
        mx_r  <= 10'd0;
      end else begin
        vld_r <= in_vld;
        if (in_vld) begin
          sym_r <= in_sym;
          h_r   <= h_new;
          dg_r  <= in_h;
          if (h_new > mx_r) mx_r <= h_new;
        end
      end
    end

    assign sym_a[i]  = sym_r;
    assign vld_a[i]  = vld_r;
    assign h_a[i]    = h_r;
    assign pmax_a[i] = mx_r;
  end

  // -------------------------------------------------------------------------
  // Global reduction. This value is sampled only in REDUCE. By then the last
  // symbol has already passed through PE QLEN-1.
  // -------------------------------------------------------------------------
  logic [9:0] gmax;

  always_comb begin
    gmax = 10'd0;
    for (int k = 0; k < QLEN; k++) begin
      if (pmax_a[k] > gmax) gmax = pmax_a[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score <= 10'd0;
    end else if (load_score) begin
      score <= gmax;
    end
  end

endmodule

// File: tb/tb_example.sv
// ---------------------------------------------------------------------------
// tb_example -- bench for the Smith-Waterman engine `example`.
//
// Five engines share one clock and one reset. Each engine holds a different
// pair of constant tables:
//   0: default tables                 3: query all A, database all C
//   1: copy with symbol 8 mismatched  4: query all A, database all A
//   2: copy with symbol 8 deleted
// For each pair, the reference score comes from a plain dynamic-programming
// fill of the full Smith-Waterman matrix. Reset timing is randomized.
// ---------------------------------------------------------------------------
module tb_example;

  localparam int QL   = 16;
  localparam int DL   = 32;
  localparam int NDUT = 5;
  localparam int LAT  = DL + QL + 4;

  // Query: ACGT repeated. Symbol k sits at bits [2k+1:2k].
  function automatic logic [2*QL-1:0] mk_query();
    logic [2*QL-1:0] v;
    v = '0;
    for (int i = 0; i < QL; i++) v[2*i +: 2] = 2'(i % 4);
    return v;
  endfunction

  // Database: TTTTTTTT, then the query, then G padding up to DL symbols.
  //   kind 0: exact copy of the query
  //   kind 1: query symbol 8 replaced by T
  //   kind 2: query symbol 8 removed
  function automatic logic [2*DL-1:0] mk_db(input int kind);
    logic [2*DL-1:0] v;
    logic [2*QL-1:0] q;
    int p;
    q = mk_query();
    v = '0;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      v[2*p +: 2] = 2'd3;
      p++;
    end
    for (int i = 0; i < QL; i++) begin
      if (!(kind == 2 && i == 8)) begin
        v[2*p +: 2] = (kind == 1 && i == 8) ? 2'd3 : q[2*i +: 2];
        p++;
      end
    end
    for (int k = 0; k < DL; k++) begin
      if (k >= p) v[2*k +: 2] = 2'd2;
    end
    return v;
  endfunction

  localparam logic [2*QL-1:0] Q_ACGT = mk_query();
  localparam logic [2*DL-1:0] D_MIS  = mk_db(1);
  localparam logic [2*DL-1:0] D_GAP  = mk_db(2);
  localparam logic [2*QL-1:0] Q_A    = '0;
  localparam logic [2*DL-1:0] D_C    = {DL{2'b01}};
  localparam logic [2*DL-1:0] D_A    = '0;

  // Reference: full Smith-Waterman matrix with match +2, mismatch -1,
  // gap -1. Each cell is clamped to the range 0..1023.
  function automatic int sw_ref(input logic [2*QL-1:0] qv, input logic [2*DL-1:0] dv);
    int h [0:QL][0:DL];
    int best, v, s;
    best = 0;
    for (int i = 0; i <= QL; i++)
      for (int j = 0; j <= DL; j++) h[i][j] = 0;
    for (int i = 1; i <= QL; i++) begin
      for (int j = 1; j <= DL; j++) begin
        s = (qv[2*(i-1) +: 2] == dv[2*(j-1) +: 2]) ? 2 : -1;
        v = h[i-1][j-1] + s;
        if (h[i-1][j] - 1 > v) v = h[i-1][j] - 1;
        if (h[i][j-1] - 1 > v) v = h[i][j-1] - 1;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        h[i][j] = v;
        if (v > best) best = v;
      end
    end
    return best;
  endfunction

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic [9:0] sc [NDUT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  example u0 (.clk(clk), .rst(rst), .score(sc[0]));
  example #(.QSEQ(Q_ACGT), .DSEQ(D_MIS)) u1 (.clk(clk), .rst(rst), .score(sc[1]));
  example #(.QSEQ(Q_ACGT), .DSEQ(D_GAP)) u2 (.clk(clk), .rst(rst), .score(sc[2]));
  example #(.QSEQ(Q_A),    .DSEQ(D_C))   u3 (.clk(clk), .rst(rst), .score(sc[3]));
  example #(.QSEQ(Q_A),    .DSEQ(D_A))   u4 (.clk(clk), .rst(rst), .score(sc[4]));

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];
  int  total = 0;
  int  bad   = 0;
  bit  mon_en = 1'b0;
  bit  seen [NDUT];
  int  rcyc;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_ok(input string name, input bit ok, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0d required=0_or_%0d", name, act, req);
    end
  endtask

  // Number of rising edges seen since reset was last released.
  always @(posedge clk or negedge rst) begin
    if (!rst) rcyc <= 0;
    else      rcyc <= rcyc + 1;
  end

  // Per-cycle check, sampled on the falling edge.
  //   - While reset is low, every score must be 0.
  //   - Before the latency bound, a score may be 0 or the final value.
  //     Once it shows the final value, it must not change again.
  //   - From the latency bound onward, every score must equal the reference.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < NDUT; d++) begin
        if (!rst)
          chk($sformatf("rst_zero[%0d]", d), sc[d], 0);
        else if (rcyc >= LAT)
          chk($sformatf("final[%0d]", d), sc[d], exp_q[d]);
        else if (seen[d])
          chk($sformatf("hold[%0d]", d), sc[d], exp_q[d]);
        else
          chk_ok($sformatf("pre_done[%0d]", d),
                 (sc[d] == 10'd0) || (sc[d] == exp_q[d]), sc[d], exp_q[d]);
        if (!rst) seen[d] = 1'b0;
        else if (exp_q[d] != 10'd0 && sc[d] == exp_q[d]) seen[d] = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_literals(input string tag);
    chk({tag, "_def"},   sc[0], 32);
    chk({tag, "_mis"},   sc[1], 29);
    chk({tag, "_gap"},   sc[2], 29);
    chk({tag, "_aacc"},  sc[3], 0);
    chk({tag, "_aaaa"},  sc[4], 32);
  endtask

  initial begin
    exp_q.push_back(10'(sw_ref(mk_query(), mk_db(0))));
    exp_q.push_back(10'(sw_ref(Q_ACGT, D_MIS)));
    exp_q.push_back(10'(sw_ref(Q_ACGT, D_GAP)));
    exp_q.push_back(10'(sw_ref(Q_A, D_C)));
    exp_q.push_back(10'(sw_ref(Q_A, D_A)));
    // Hand-computed values that pin the reference model itself.
    chk("model_def",  exp_q[0], 32);
    chk("model_mis",  exp_q[1], 29);
    chk("model_gap",  exp_q[2], 29);
    chk("model_aacc", exp_q[3], 0);
    chk("model_aaaa", exp_q[4], 32);
    for (int d = 0; d < NDUT; d++) seen[d] = 1'b0;

    // Power-on reset: drive a real falling edge, hold 2 cycles, release.
    rst = 1'b1;
    #1 rst = 1'b0;
    mon_en = 1'b1;
    step(2);
    rst = 1'b1;
    step(LAT + 3);
    chk_literals("first_run");

    // Abort at cycle 20 of a run, then restart.
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(20);
    rst = 1'b0;
    #1 chk("abort_c20", sc[0], 0);
    step(1);
    rst = 1'b1;
    step(LAT);
    chk("restart_c20", sc[0], 32);

    // Reset pulses at random points in the run, including after DONE.
    for (int t = 0; t < 12; t++) begin
      step($urandom_range(1, 70));
      rst = 1'b0;
      #1 chk("abort_rand", sc[0], 0);
      step($urandom_range(1, 3));
      rst = 1'b1;
    end
    step(LAT + 1);
    chk_literals("after_rand");

    // Long hold: the per-cycle check confirms the scores never move.
    step(35000);
    chk_literals("long_hold");

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
